// File: rtl/add_sub_pkg.sv
// Shared constants for the floating-point add/sub datapath.
// Widths default to IEEE-754 single precision.
package add_sub_pkg;

  localparam int SIZE_EXP = 8;
  localparam int SIZE_MAN = 23;
  localparam int EXP_MAX  = 255;
  localparam int BIAS     = 127;

  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] INF      = 32'h7F80_0000;

endpackage

// File: rtl/add_sub_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module add_sub_lzc #(
  parameter int WIDTH = 27,
  parameter int CNT_W = 5
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  logic found;

  // NOTE: every output of a combinational block gets a default first so that
  // no path leaves it unassigned and a latch is inferred.
  always_comb begin
    count = CNT_W'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && data[i]) begin
        count = CNT_W'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_sub_post_norm.sv
// Post-normalisation of an add/sub magnitude: S1 classifies and counts leading
// zeros, S2 shifts, rounds to nearest even and packs the IEEE-754 result.
module add_sub_post_norm
  import add_sub_pkg::*;
#(
  parameter int SIZE_EXP = add_sub_pkg::SIZE_EXP,
  parameter int SIZE_MAN = add_sub_pkg::SIZE_MAN
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_sign,
  input  logic [SIZE_EXP-1:0]          i_exp,
  input  logic [SIZE_MAN+4:0]          i_mant,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [SIZE_EXP+SIZE_MAN:0]   o_data,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int MW = SIZE_MAN + 5;
  localparam int NW = SIZE_MAN + 4;
  localparam int CW = $clog2(NW + 1);
  localparam int EW = SIZE_EXP + 2;
  localparam int DW = 1 + SIZE_EXP + SIZE_MAN;

  logic                s1_valid;
  logic                s1_sign;
  logic                s1_zero;
  logic                s1_carry;
  logic [SIZE_EXP-1:0] s1_exp;
  logic [MW-1:0]       s1_mant;
  logic [CW-1:0]       s1_lz;
  logic [CW-1:0]       lz;
  logic                s2_adv;
  logic                in_fire;

  add_sub_lzc #(.WIDTH(NW), .CNT_W(CW)) u_lzc (
    .data  (i_mant[NW-1:0]),
    .count (lz)
  );

  assign s2_adv  = ~o_valid | i_ready;
  assign o_ready = ~s1_valid | s2_adv;
  assign in_fire = i_valid & o_ready;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        s1_valid <= 1'b0;
    else if (o_ready) s1_valid <= i_valid;
  end

  // NOTE: stage payload is left unreset; the valid bit alone decides whether
  // it is ever consumed, which keeps reset fan-out off the wide datapath.
  always_ff @(posedge i_clk) begin
    if (in_fire) begin
      s1_sign  <= i_sign;
      s1_exp   <= i_exp;
      s1_mant  <= i_mant;
      s1_zero  <= ~|i_mant;
      s1_carry <= i_mant[MW-1];
      s1_lz    <= lz;
    end
  end

  logic [EW-1:0]       exp_ext, lz_ext, exp_dec, exp_norm, exp_fin;
  logic [NW-1:0]       norm;
  logic                flush, round_up, res_of, res_uf;
  logic [SIZE_MAN+1:0] rounded;
  logic [SIZE_MAN-1:0] frac;
  logic [DW-1:0]       res;

  assign exp_ext = EW'(s1_exp);
  assign lz_ext  = EW'(s1_lz);
  // Shared CLA subtract form: A + ~B + 1.
  assign exp_dec = exp_ext + ~lz_ext + EW'(1);

  always_comb begin
    norm     = '0;
    exp_norm = '0;
    flush    = 1'b0;
    exp_fin  = '0;
    frac     = '0;
    res      = '0;
    res_of   = 1'b0;
    res_uf   = 1'b0;
    if (s1_carry) begin
      // The bit shifted out of the right end folds into sticky.
      norm     = {s1_mant[MW-1:2], s1_mant[1] | s1_mant[0]};
      exp_norm = exp_ext + EW'(1);
    end else begin
      norm     = s1_mant[NW-1:0] << s1_lz;
      exp_norm = exp_dec;
      flush    = (exp_ext <= lz_ext);
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[NW-1:3]} + {{(SIZE_MAN+1){1'b0}}, round_up};
    if (rounded[SIZE_MAN+1]) begin
      frac    = '0;
      exp_fin = exp_norm + EW'(1);
    end else begin
      frac    = rounded[SIZE_MAN-1:0];
      exp_fin = exp_norm;
    end
    if (s1_zero) begin
      res = DW'(POS_ZERO);
    end else if (flush) begin
      res    = {s1_sign, {(DW-1){1'b0}}};
      res_uf = 1'b1;
    end else if (exp_fin >= EW'(2**SIZE_EXP - 1)) begin
      res    = {s1_sign, {SIZE_EXP{1'b1}}, {SIZE_MAN{1'b0}}};
      res_of = 1'b1;
    end else begin
      res = {s1_sign, exp_fin[SIZE_EXP-1:0], frac};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (s2_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_data      <= res;
        o_overflow  <= res_of;
        o_underflow <= res_uf;
      end
    end
  end

endmodule
